// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter: round-robin arbiter for NUM_REQ requesters sharing one      |
// | single-port synchronous memory (IDLE -> ISSUE -> CAPTURE).  Rev 1.0      |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ-1:0]        i_req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic [NUM_REQ-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]         o_rsp_rdata,
  output logic                      o_busy,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic                      o_mem_re,
  output logic                      o_mem_we,
  output logic [DATA_W-1:0]         o_mem_din,
  input  logic [DATA_W-1:0]         i_mem_dout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_rr_ptr, w_rr_ptr_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic                r_wr, w_wr_nxt;
  logic [NUM_REQ-1:0]  r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0]  r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
  logic                r_busy, w_busy_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic                r_mem_re, w_mem_re_nxt;
  logic                r_mem_we, w_mem_we_nxt;
  logic [DATA_W-1:0]   r_mem_din, w_mem_din_nxt;

  logic                w_found;
  logic [IDX_W-1:0]    w_sel;

  // Round-robin search: first valid requester at or after r_rr_ptr, wrapping.
  always_comb begin
    int v_idx;
    w_found = 1'b0;
    w_sel   = '0;
    v_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && i_req_valid[v_idx]) begin
        w_found = 1'b1;
        w_sel   = IDX_W'(v_idx);
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_idx_nxt       = r_idx;
    w_wr_nxt        = r_wr;
    w_grant_nxt     = '0;
    w_rsp_valid_nxt = '0;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_din_nxt   = r_mem_din;
    w_mem_re_nxt    = 1'b0;
    w_mem_we_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_nxt    = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel;
          w_mem_addr_nxt = i_req_addr[w_sel*ADDR_W +: ADDR_W];
          w_mem_din_nxt  = i_req_wdata[w_sel*DATA_W +: DATA_W];
          w_mem_re_nxt   = !i_req_write[w_sel];
          w_mem_we_nxt   = i_req_write[w_sel];
          w_idx_nxt      = w_sel;
          w_wr_nxt       = i_req_write[w_sel];
          w_rr_ptr_nxt   = IDX_W'((int'(w_sel) + 1) % NUM_REQ);
          w_state_nxt    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        // Memory output is registered, so read data is valid in this cycle.
        w_rsp_valid_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_idx;
        if (!r_wr) begin
          w_rsp_rdata_nxt = i_mem_dout;
        end
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_rr_ptr    <= '0;
      r_idx       <= '0;
      r_wr        <= 1'b0;
      r_grant     <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_busy      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_din   <= '0;
    end else begin
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_idx       <= w_idx_nxt;
      r_wr        <= w_wr_nxt;
      r_grant     <= w_grant_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_busy      <= w_busy_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_re    <= w_mem_re_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_din   <= w_mem_din_nxt;
    end
  end

  assign o_grant     = r_grant;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_busy      = r_busy;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_re    = r_mem_re;
  assign o_mem_we    = r_mem_we;
  assign o_mem_din   = r_mem_din;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_arbiter: scoreboard bench for mem_arbiter with a registered       |
// | memory model. Rev 1.0                                                    |
// +--------------------------------------------------------------------------+
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_write;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  grant;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic [7:0]  mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  mem_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(16)) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_req_valid (req_valid),
    .i_req_write (req_write),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_grant     (grant),
    .o_rsp_valid (rsp_valid),
    .o_rsp_rdata (rsp_rdata),
    .o_busy      (busy),
    .o_mem_addr  (mem_addr),
    .o_mem_re    (mem_re),
    .o_mem_we    (mem_we),
    .o_mem_din   (mem_din),
    .i_mem_dout  (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Unwritten locations read back as {8'hA5, addr}.
  logic [15:0] mem [0:255];
  bit          mem_wr [0:255];
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]    <= mem_din;
      mem_wr[mem_addr] <= 1'b1;
    end
    if (mem_re) mem_dout <= mem_wr[mem_addr] ? mem[mem_addr] : {8'hA5, mem_addr};
  end

  typedef struct {
    int          cyc;
    logic [3:0]  g;
    logic        re;
    logic        we;
    logic [7:0]  a;
    logic [15:0] d;
  } gexp_t;

  typedef struct {
    int          cyc;
    logic [3:0]  v;
    logic [15:0] rd;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  logic [15:0] last_rd = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [7:0] a, input logic [15:0] d);
    req_write[i]         = wr;
    req_addr[i*8 +: 8]   = a;
    req_wdata[i*16 +: 16] = d;
  endtask

  task automatic push_grant(input int i, input logic wr, input logic [7:0] a,
                            input logic [15:0] d, input int gc);
    gexp_t e;
    e.cyc = gc; e.g = 4'b0001 << i; e.re = !wr; e.we = wr; e.a = a; e.d = d;
    gq.push_back(e);
  endtask

  task automatic push_txn(input int i, input logic wr, input logic [7:0] a,
                          input logic [15:0] d, input logic [15:0] rd, input int gc);
    rexp_t r;
    push_grant(i, wr, a, d, gc);
    if (!wr) last_rd = rd;
    r.cyc = gc + 2; r.v = 4'b0001 << i; r.rd = last_rd;
    rq.push_back(r);
  endtask

  task automatic single(input int i, input logic wr, input logic [7:0] a,
                        input logic [15:0] d, input logic [15:0] rd);
    set_req(i, wr, a, d);
    req_valid = 4'b0001 << i;
    push_txn(i, wr, a, d, rd, cyc + 1);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_grant"},     {28'h0, grant},     32'h0);
    chk({tag, "_rsp_valid"}, {28'h0, rsp_valid}, 32'h0);
    chk({tag, "_rsp_rdata"}, {16'h0, rsp_rdata}, 32'h0);
    chk({tag, "_busy"},      {31'h0, busy},      32'h0);
    chk({tag, "_mem_addr"},  {24'h0, mem_addr},  32'h0);
    chk({tag, "_mem_re"},    {31'h0, mem_re},    32'h0);
    chk({tag, "_mem_we"},    {31'h0, mem_we},    32'h0);
    chk({tag, "_mem_din"},   {16'h0, mem_din},   32'h0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant or response.
  gexp_t ge;
  rexp_t re_;
  always @(negedge clk) begin
    if (!rst) begin
      chk("strobe_exclusive", {31'h0, mem_re & mem_we}, 32'h0);
      chk("strobe_vs_grant", {31'h0, (mem_re | mem_we) != (grant != 4'b0)}, 32'h0);
      if (grant != 4'b0) begin
        if (gq.size() == 0) begin
          chk("unexpected_grant", {28'h0, grant}, 32'h0);
        end else begin
          ge = gq.pop_front();
          chk("grant_cycle", cyc,                ge.cyc);
          chk("grant_value", {28'h0, grant},     {28'h0, ge.g});
          chk("mem_re",      {31'h0, mem_re},    {31'h0, ge.re});
          chk("mem_we",      {31'h0, mem_we},    {31'h0, ge.we});
          chk("mem_addr",    {24'h0, mem_addr},  {24'h0, ge.a});
          if (ge.we) chk("mem_din", {16'h0, mem_din}, {16'h0, ge.d});
          chk("busy_issue",  {31'h0, busy},      32'h1);
        end
      end
      if (rsp_valid != 4'b0) begin
        if (rq.size() == 0) begin
          chk("unexpected_rsp", {28'h0, rsp_valid}, 32'h0);
        end else begin
          re_ = rq.pop_front();
          chk("rsp_cycle", cyc,                 re_.cyc);
          chk("rsp_valid", {28'h0, rsp_valid},  {28'h0, re_.v});
          chk("rsp_rdata", {16'h0, rsp_rdata},  {16'h0, re_.rd});
          chk("busy_rsp",  {31'h0, busy},       32'h0);
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    req_valid = 4'b0;
    req_write = 4'b0;
    req_addr  = 32'h0;
    req_wdata = 64'h0;
    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    tick();

    // Write from requester 1, then read it back from requester 2.
    single(1, 1'b1, 8'h10, 16'hBEEF, 16'h0);
    single(2, 1'b0, 8'h10, 16'h0000, 16'hBEEF);

    // Back-to-back reads by requester 0, re-requested in the rsp_valid cycle.
    single(0, 1'b0, 8'h20, 16'h0000, 16'hA520);
    single(0, 1'b0, 8'h21, 16'h0000, 16'hA521);
    tick();

    // Reset restores rr_ptr=0; all four request for 12 cycles.
    rst = 1'b1;
    #1;
    check_reset_outputs("rst2");
    tick();
    rst = 1'b0;
    last_rd = 16'h0;
    tick();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'h30 + 8'(i), 16'h0);
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++)
      push_txn(i, 1'b0, 8'h30 + 8'(i), 16'h0, 16'hA530 + 16'(i), cyc + 1 + 3*i);
    repeat (12) tick();
    req_valid = 4'b0000;
    tick();

    // After a grant to 3, requesters 0 and 3 collide: 0 wins first.
    set_req(0, 1'b0, 8'h50, 16'h0);
    set_req(3, 1'b0, 8'h53, 16'h0);
    req_valid = 4'b1001;
    push_txn(0, 1'b0, 8'h50, 16'h0, 16'hA550, cyc + 1);
    push_txn(3, 1'b0, 8'h53, 16'h0, 16'hA553, cyc + 4);
    repeat (3) tick();
    req_valid = 4'b1000;
    repeat (3) tick();
    req_valid = 4'b0000;
    tick();

    // Reset mid-ISSUE of a write: access abandoned, memory untouched.
    set_req(1, 1'b1, 8'h40, 16'h1234);
    req_valid = 4'b0010;
    push_grant(1, 1'b1, 8'h40, 16'h1234, cyc + 1);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    #1;
    chk("we_before_reset", {31'h0, mem_we}, 32'h1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #2;
    rst = 1'b0;
    last_rd = 16'h0;
    repeat (4) tick();
    single(1, 1'b0, 8'h40, 16'h0, 16'hA540);
    repeat (3) tick();

    chk("grant_queue_empty", gq.size(), 32'h0);
    chk("rsp_queue_empty",   rq.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
